pipe_alu_rf: RTL and testbench
==============================

PIPE_ALU_RF -- requirements
Module: pipe_alu_rf

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result/register width in bits (>=4).
REQ-002 SHALL have parameter NREG, default 16, register-file depth (power of two >=2); AW = log2(NREG) is derived.
REQ-003 SHALL have port clk  input  1  single rising-edge clock.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  command present.
REQ-006 SHALL have port in_ready  output  1  command accepted when in_valid && in_ready at a rising edge.
REQ-007 SHALL have port op  input  3  000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 LOAD; 101-111 illegal.
REQ-008 SHALL have ports rd, rs1, rs2  input  AW each  destination and source register addresses.
REQ-009 SHALL have port imm  input  WIDTH  LOAD data.
REQ-010 SHALL have ports cin, bin  input  1 each  carry-in for ADD, borrow-in for SUB.
REQ-011 SHALL have ports wb_valid  output  1, wb_addr  output  AW, wb_data  output  WIDTH  registered write-back report.
REQ-012 SHALL have port rem_out  output  WIDTH  remainder of the last completed DIV.
REQ-013 SHALL have port exc  output  5  sticky flags: [0] ADD carry-out, [1] SUB borrow-out, [2] MUL overflow, [3] divide-by-zero, [4] illegal op.
REQ-014 SHALL have port exc_clr  input  1  clears exc.
REQ-015 SHALL have ports dbg_addr  input  AW, dbg_data  output  WIDTH  combinational register-file read.

Function
REQ-016 SHALL hold NREG x WIDTH registers; operands are read from rs1/rs2 in the accepting cycle.
REQ-017 SHALL use an FSM with states IDLE and DIV_RUN; in_ready = 1 only in IDLE.
REQ-018 ADD, SUB, MUL, LOAD SHALL write rd at the accepting edge and pulse wb_valid for exactly one cycle after that edge, with wb_addr = rd and wb_data = the result; latency is 1.
REQ-019 ADD SHALL produce the low WIDTH bits of rs1+rs2+cin and set exc[0] if the carry-out is 1.
REQ-020 SUB SHALL produce the low WIDTH bits of rs1-rs2-bin and set exc[1] if a borrow occurs.
REQ-021 MUL SHALL be unsigned, SHALL write the low WIDTH bits of the product, and SHALL set exc[2] if the upper WIDTH bits are nonzero.
REQ-022 LOAD SHALL write imm.
REQ-023 DIV with rs2 != 0 SHALL latch the operands, enter DIV_RUN, and perform an unsigned restoring division at one quotient bit per cycle.
REQ-024 DIV with rs2 != 0 SHALL write the quotient to rd, load rem_out, pulse wb_valid, and return to IDLE at the WIDTH-th edge after acceptance; latency is WIDTH.
REQ-025 DIV with rs2 == 0 SHALL complete in 1 cycle: write all-ones to rd, set rem_out = rs1, set exc[3], and stay in IDLE.
REQ-026 An illegal op SHALL be accepted, SHALL NOT write the register file, SHALL NOT pulse wb_valid, and SHALL set exc[4].
REQ-027 exc bits SHALL be sticky until exc_clr; if a set and exc_clr coincide in the same cycle, the set SHALL win.
REQ-028 rd == rs1 or rd == rs2 SHALL be legal; operands use the pre-write values.
REQ-029 A command accepted in the cycle right after a write SHALL read the newly written value.
REQ-030 in_valid during DIV_RUN SHALL be ignored; the command is not accepted, and the source holds it until in_ready is high.
REQ-031 dbg_data SHALL reflect a write from the cycle after the write edge onward.

Reset
REQ-032 rst_n low SHALL asynchronously clear all registers, rem_out, exc, wb_valid, wb_addr, wb_data, and the divider state, and force IDLE with in_ready = 1.
REQ-033 Reset asserted during DIV_RUN SHALL abort the division with no write-back.
REQ-034 The first command SHALL be accepted at the first rising edge after rst_n deasserts.

Verification (WIDTH=16, NREG=16)
REQ-035 LOAD r1=0xFFFF, LOAD r2=0x0001, ADD rd=3 rs1=1 rs2=2 cin=0 -> r3=0x0000, exc[0]=1, wb_valid one cycle with wb_addr=3.
REQ-036 LOAD r1=100, r2=7, DIV rd=4 -> in_ready low for 15 cycles; at edge 16, r4=14, rem_out=2, and wb_valid pulses.
REQ-037 DIV with r2=0, r1=0x1234 -> 1-cycle completion, rd=0xFFFF, rem_out=0x1234, exc[3]=1; exc_clr pulse -> exc=0.
REQ-038 MUL r1=0x0100 x r2=0x0100 -> rd=0x0000, exc[2]=1; MUL 0x00FF x 0x0002 -> 0x01FE, with no new flag.
REQ-039 Back-to-back LOAD r5=9, then ADD rd=6 rs1=5 rs2=5 -> r6=18, showing the prior write is visible.
REQ-040 rst_n pulsed low 5 cycles into a DIV -> no wb_valid, all registers 0, in_ready=1; op=111 -> exc[4]=1 and no write.

Source files
------------

// File: rtl/pipe_alu_rf.sv
// Register-file ALU with one-cycle ADD/SUB/MUL/LOAD and a
// multi-cycle restoring divider; sticky exception flags.
module pipe_alu_rf #(
   parameter  int WIDTH = 16,
   parameter  int NREG  = 16,
   localparam int AW    = $clog2(NREG)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [AW-1:0]    rd,
   input  logic [AW-1:0]    rs1,
   input  logic [AW-1:0]    rs2,
   input  logic [WIDTH-1:0] imm,
   input  logic             cin,
   input  logic             bin,
   output logic             wb_valid,
   output logic [AW-1:0]    wb_addr,
   output logic [WIDTH-1:0] wb_data,
   output logic [WIDTH-1:0] rem_out,
   output logic [4:0]       exc,
   input  logic             exc_clr,
   input  logic [AW-1:0]    dbg_addr,
   output logic [WIDTH-1:0] dbg_data
);

   typedef enum logic {IDLE, DIV_RUN} state_t;

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_MUL  = 3'b010;
   localparam logic [2:0] OP_DIV  = 3'b011;
   localparam logic [2:0] OP_LOAD = 3'b100;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] rf_q [NREG];
   logic [WIDTH-1:0] rf_d [NREG];
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] rem_out_q, rem_out_d;
   logic [WIDTH-1:0] wb_data_q, wb_data_d;
   logic [AW-1:0]    drd_q, drd_d;
   logic [AW-1:0]    wb_addr_q, wb_addr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             wb_valid_q, wb_valid_d;
   logic [4:0]       exc_q, exc_d, exc_set;

   logic [WIDTH-1:0]   a, b;
   logic [WIDTH:0]     sum, dif;
   logic [2*WIDTH-1:0] prod;

   logic [WIDTH-1:0] sx_rem, sx_quo, sx_dvs;
   logic [WIDTH-1:0] st_rem, st_quo;
   logic [WIDTH:0]   trial;
   logic             ge;

   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [WIDTH-1:0] wr_data;

   assign a    = rf_q[rs1];
   assign b    = rf_q[rs2];
   assign sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
   assign dif  = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};
   assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

   assign in_ready = (state_q == IDLE);
   assign wb_valid = wb_valid_q;
   assign wb_addr  = wb_addr_q;
   assign wb_data  = wb_data_q;
   assign rem_out  = rem_out_q;
   assign exc      = exc_q;
   assign dbg_data = rf_q[dbg_addr];

   // The first quotient bit is produced on the accepting edge.
   always_comb begin
      if (state_q == DIV_RUN) begin
         sx_rem = rem_q;
         sx_quo = quo_q;
         sx_dvs = dvs_q;
      end else begin
         sx_rem = '0;
         sx_quo = a;
         sx_dvs = b;
      end
      trial  = {sx_rem, sx_quo[WIDTH-1]};
      ge     = (trial >= {1'b0, sx_dvs});
      st_rem = ge ? (trial[WIDTH-1:0] - sx_dvs) : trial[WIDTH-1:0];
      st_quo = {sx_quo[WIDTH-2:0], ge};
   end

   always_comb begin
      state_d   = state_q;
      rf_d      = rf_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      drd_d     = drd_q;
      cnt_d     = cnt_q;
      rem_out_d = rem_out_q;
      exc_set   = '0;
      wr_en     = 1'b0;
      wr_addr   = rd;
      wr_data   = '0;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               case (op)
                  OP_ADD: begin
                     wr_en      = 1'b1;
                     wr_data    = sum[WIDTH-1:0];
                     exc_set[0] = sum[WIDTH];
                  end
                  OP_SUB: begin
                     wr_en      = 1'b1;
                     wr_data    = dif[WIDTH-1:0];
                     exc_set[1] = dif[WIDTH];
                  end
                  OP_MUL: begin
                     wr_en      = 1'b1;
                     wr_data    = prod[WIDTH-1:0];
                     exc_set[2] = |prod[2*WIDTH-1:WIDTH];
                  end
                  OP_LOAD: begin
                     wr_en   = 1'b1;
                     wr_data = imm;
                  end
                  OP_DIV: begin
                     if (b == '0) begin
                        wr_en      = 1'b1;
                        wr_data    = '1;
                        rem_out_d  = a;
                        exc_set[3] = 1'b1;
                     end else begin
                        rem_d   = st_rem;
                        quo_d   = st_quo;
                        dvs_d   = b;
                        drd_d   = rd;
                        cnt_d   = CW'(1);
                        state_d = DIV_RUN;
                     end
                  end
                  default: exc_set[4] = 1'b1;
               endcase
            end
         end
         DIV_RUN: begin
            rem_d = st_rem;
            quo_d = st_quo;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               wr_en     = 1'b1;
               wr_addr   = drd_q;
               wr_data   = st_quo;
               rem_out_d = st_rem;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      wb_valid_d = wr_en;
      wb_addr_d  = wb_addr_q;
      wb_data_d  = wb_data_q;
      if (wr_en) begin
         rf_d[wr_addr] = wr_data;
         wb_addr_d     = wr_addr;
         wb_data_d     = wr_data;
      end

      // A new flag outranks a simultaneous clear.
      exc_d = (exc_clr ? 5'b0 : exc_q) | exc_set;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
         rem_q      <= '0;
         quo_q      <= '0;
         dvs_q      <= '0;
         drd_q      <= '0;
         cnt_q      <= '0;
         rem_out_q  <= '0;
         wb_valid_q <= 1'b0;
         wb_addr_q  <= '0;
         wb_data_q  <= '0;
         exc_q      <= '0;
      end else begin
         state_q    <= state_d;
         rf_q       <= rf_d;
         rem_q      <= rem_d;
         quo_q      <= quo_d;
         dvs_q      <= dvs_d;
         drd_q      <= drd_d;
         cnt_q      <= cnt_d;
         rem_out_q  <= rem_out_d;
         wb_valid_q <= wb_valid_d;
         wb_addr_q  <= wb_addr_d;
         wb_data_q  <= wb_data_d;
         exc_q      <= exc_d;
      end
   end

endmodule

// File: tb/tb_pipe_alu_rf.sv
// Scoreboard bench for pipe_alu_rf: directed commands queue expected
// write-backs; a negedge monitor pops and compares them.
module tb_pipe_alu_rf;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  op;
   logic [3:0]  rd, rs1, rs2;
   logic [15:0] imm;
   logic        cin, bin;
   logic        wb_valid;
   logic [3:0]  wb_addr;
   logic [15:0] wb_data;
   logic [15:0] rem_out;
   logic [4:0]  exc;
   logic        exc_clr;
   logic [3:0]  dbg_addr;
   logic [15:0] dbg_data;

   int checks = 0;
   int errors = 0;
   logic [19:0] exp_q [$];

   pipe_alu_rf #(.WIDTH(16), .NREG(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .rd(rd), .rs1(rs1), .rs2(rs2),
      .imm(imm), .cin(cin), .bin(bin),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
      .rem_out(rem_out), .exc(exc), .exc_clr(exc_clr),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
      end
   endtask

   always @(negedge clk) begin
      if (wb_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL wb_unexpected: got addr %0d data 0x%0h expected none",
                     wb_addr, wb_data);
         end else begin
            logic [19:0] e;
            e = exp_q.pop_front();
            chk("wb_addr", 32'(wb_addr), 32'(e[19:16]));
            chk("wb_data", 32'(wb_data), 32'(e[15:0]));
         end
      end
   end

   task automatic expect_wb(input int a, input logic [15:0] d);
      exp_q.push_back({4'(a), d});
   endtask

   task automatic issue(input logic [2:0] o, input int d, input int s1,
                        input int s2, input logic [15:0] im,
                        input logic c, input logic bw);
      int n;
      @(negedge clk);
      op = o; rd = 4'(d); rs1 = 4'(s1); rs2 = 4'(s2);
      imm = im; cin = c; bin = bw;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL issue_timeout: got in_ready 0 expected 1");
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic load(input int d, input logic [15:0] v);
      expect_wb(d, v);
      issue(3'b100, d, 0, 0, v, 1'b0, 1'b0);
   endtask

   task automatic rf_chk(input string name, input int a,
                         input logic [15:0] want);
      dbg_addr = 4'(a);
      #1 chk(name, 32'(dbg_data), 32'(want));
   endtask

   task automatic clr_exc();
      @(negedge clk);
      exc_clr = 1'b1;
      @(negedge clk);
      exc_clr = 1'b0;
      chk("exc_clr", 32'(exc), 32'h0);
   endtask

   task automatic all_zero(input string name);
      logic [15:0] acc;
      acc = '0;
      for (int i = 0; i < 16; i++) begin
         dbg_addr = 4'(i);
         #1 acc = acc | dbg_data;
      end
      chk(name, 32'(acc), 32'h0);
   endtask

   initial begin
      int cnt;
      rst_n = 1'b0; in_valid = 1'b0; op = '0; rd = '0; rs1 = '0;
      rs2 = '0; imm = '0; cin = 1'b0; bin = 1'b0; exc_clr = 1'b0;
      dbg_addr = '0;
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'h1);
      chk("rst_wb_valid", 32'(wb_valid), 32'h0);
      chk("rst_exc", 32'(exc), 32'h0);
      chk("rst_rem_out", 32'(rem_out), 32'h0);
      all_zero("rst_regs");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // ADD with carry-out
      load(1, 16'hFFFF);
      load(2, 16'h0001);
      expect_wb(3, 16'h0000);
      issue(3'b000, 3, 1, 2, 16'h0, 1'b0, 1'b0);
      chk("add_carry_exc", 32'(exc), 32'h01);
      rf_chk("add_r3", 3, 16'h0000);
      clr_exc();

      // 100 / 7 multi-cycle divide
      load(1, 16'd100);
      load(2, 16'd7);
      expect_wb(4, 16'd14);
      issue(3'b011, 4, 1, 2, 16'h0, 1'b0, 1'b0);
      cnt = 0;
      @(negedge clk);
      while (!in_ready && cnt < 100) begin
         cnt++;
         @(negedge clk);
      end
      chk("div_busy_cycles", 32'(cnt), 32'd15);
      chk("div_rem", 32'(rem_out), 32'd2);
      rf_chk("div_r4", 4, 16'd14);

      // divide by zero
      load(1, 16'h1234);
      load(2, 16'h0000);
      expect_wb(5, 16'hFFFF);
      issue(3'b011, 5, 1, 2, 16'h0, 1'b0, 1'b0);
      chk("dz_exc", 32'(exc), 32'h08);
      chk("dz_rem", 32'(rem_out), 32'h1234);
      rf_chk("dz_r5", 5, 16'hFFFF);
      @(negedge clk);
      chk("dz_in_ready", 32'(in_ready), 32'h1);
      clr_exc();

      // set and clear on the same edge: set wins
      exc_clr = 1'b1;
      expect_wb(5, 16'hFFFF);
      issue(3'b011, 5, 1, 2, 16'h0, 1'b0, 1'b0);
      exc_clr = 1'b0;
      chk("set_beats_clr", 32'(exc), 32'h08);
      clr_exc();

      // MUL overflow, then in range
      load(1, 16'h0100);
      load(2, 16'h0100);
      expect_wb(7, 16'h0000);
      issue(3'b010, 7, 1, 2, 16'h0, 1'b0, 1'b0);
      chk("mul_ovf_exc", 32'(exc), 32'h04);
      clr_exc();
      load(1, 16'h00FF);
      load(2, 16'h0002);
      expect_wb(8, 16'h01FE);
      issue(3'b010, 8, 1, 2, 16'h0, 1'b0, 1'b0);
      chk("mul_ok_exc", 32'(exc), 32'h00);

      // SUB with borrow-in: 2 - 255 - 1
      expect_wb(9, 16'hFF02);
      issue(3'b001, 9, 2, 1, 16'h0, 1'b0, 1'b1);
      chk("sub_borrow_exc", 32'(exc), 32'h02);
      clr_exc();

      // ADD with carry-in, no carry-out: 255 + 2 + 1
      expect_wb(10, 16'h0102);
      issue(3'b000, 10, 1, 2, 16'h0, 1'b1, 1'b0);
      chk("add_cin_exc", 32'(exc), 32'h00);

      // back-to-back forwarding through the register file
      load(5, 16'd9);
      expect_wb(6, 16'd18);
      issue(3'b000, 6, 5, 5, 16'h0, 1'b0, 1'b0);
      expect_wb(6, 16'd36);
      issue(3'b000, 6, 6, 6, 16'h0, 1'b0, 1'b0);
      rf_chk("alias_r6", 6, 16'd36);

      // reset in the middle of a divide
      issue(3'b011, 11, 6, 5, 16'h0, 1'b0, 1'b0);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_in_ready", 32'(in_ready), 32'h1);
      chk("abort_wb_valid", 32'(wb_valid), 32'h0);
      chk("abort_rem", 32'(rem_out), 32'h0);
      all_zero("abort_regs");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      rf_chk("abort_r11", 11, 16'h0);

      // illegal op: flag only, no write
      load(1, 16'h0055);
      issue(3'b111, 1, 0, 0, 16'h00AA, 1'b0, 1'b0);
      chk("illegal_exc", 32'(exc), 32'h10);
      rf_chk("illegal_r1", 1, 16'h0055);
      repeat (4) @(negedge clk);

      chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
